// File: rtl/arriving_uranus_if.sv
// Airlock control bundle: port sensors, ship/operator requests, timer
// handshake and status outputs shared between the controller and its
// environment.
interface arriving_uranus_if;
   logic       innerPort;
   logic       outerPort;
   logic       arriving;
   logic       evac;
   logic       pressurize;
   logic [2:0] counterVal;
   logic       rstCounter;
   logic [6:0] display;
   logic       busy;
   logic       fault;

   // Environment side: drives sensors/requests, observes controller outputs.
   modport master (
      output innerPort, outerPort, arriving, evac, pressurize, counterVal,
      input  rstCounter, display, busy, fault
   );

   // Controller side.
   modport slave (
      input  innerPort, outerPort, arriving, evac, pressurize, counterVal,
      output rstCounter, display, busy, fault
   );
endinterface

// File: rtl/arriving_uranus.sv
// Airlock entry sequencer for an arriving ship. Walks the chamber through
// arrive, evacuate, outer-port docking, pressurize and inner-port release,
// timing the evacuate/pressurize phases with a shared external counter and
// latching FAULT whenever a port opens at an unsafe moment.
module arriving_uranus (
   input  logic             clock,
   input  logic             rst,
   arriving_uranus_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ARRIVE     = 4'd1,
      S_WAIT_EVAC  = 4'd2,
      S_EVAC       = 4'd3,
      S_OUTER_OPEN = 4'd4,
      S_DOCKED     = 4'd5,
      S_WAIT_PRESS = 4'd6,
      S_PRESS      = 4'd7,
      S_INNER_OPEN = 4'd8,
      S_FAULT      = 4'd9
   } state_t;

   // Active-low segments, bit order g..a.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_P     = 7'b0001100;
   localparam logic [6:0] SEG_F     = 7'b0001110;

   state_t     r_ps;
   state_t     w_ns;
   logic       w_closed;
   logic       w_any_open;
   logic       w_both_open;
   logic       w_rst_counter;
   logic [6:0] w_display;
   logic       w_busy;
   logic       w_fault;

   assign w_closed    = ~bus.outerPort & ~bus.innerPort;
   assign w_any_open  =  bus.outerPort |  bus.innerPort;
   assign w_both_open =  bus.outerPort &  bus.innerPort;

   // Present-state register; reset returns to IDLE from anywhere, FAULT included.
   always_ff @(posedge clock) begin
      if (rst) r_ps <= S_IDLE;
      else     r_ps <= w_ns;
   end

   // Next-state selection; an open port during a timed phase beats counter completion.
   always_comb begin
      w_ns = r_ps;
      case (r_ps)
         S_IDLE:       if (bus.arriving & w_closed) w_ns = S_ARRIVE;
         S_ARRIVE:     if (w_any_open) w_ns = S_FAULT;
                       else if (bus.counterVal >= 3'd1) w_ns = S_WAIT_EVAC;
         S_WAIT_EVAC:  if (bus.evac & w_closed) w_ns = S_EVAC;
         S_EVAC:       if (w_any_open) w_ns = S_FAULT;
                       else if (bus.counterVal >= 3'd2) w_ns = S_OUTER_OPEN;
         S_OUTER_OPEN: if (bus.outerPort & ~bus.innerPort) w_ns = S_DOCKED;
         S_DOCKED:     if (w_both_open) w_ns = S_FAULT;
                       else if (w_closed & ~bus.arriving) w_ns = S_WAIT_PRESS;
         S_WAIT_PRESS: if (bus.pressurize & w_closed) w_ns = S_PRESS;
         S_PRESS:      if (w_any_open) w_ns = S_FAULT;
                       else if (bus.counterVal >= 3'd4) w_ns = S_INNER_OPEN;
         S_INNER_OPEN: if (w_both_open) w_ns = S_FAULT;
                       else if (bus.innerPort & ~bus.outerPort) w_ns = S_IDLE;
         S_FAULT:      w_ns = S_FAULT;
         default:      w_ns = S_IDLE;
      endcase
   end

   // Status outputs from present state and inputs, held at idle values while rst is high.
   always_comb begin
      w_rst_counter = 1'b0;
      w_display     = SEG_BLANK;
      w_busy        = 1'b0;
      w_fault       = 1'b0;
      if (!rst) begin
         w_busy  = (r_ps != S_IDLE);
         w_fault = (r_ps == S_FAULT);
         // Timer clear coincides with the cycle that launches a timed phase.
         w_rst_counter = w_closed & (((r_ps == S_IDLE)       & bus.arriving) |
                                     ((r_ps == S_WAIT_EVAC)  & bus.evac)     |
                                     ((r_ps == S_WAIT_PRESS) & bus.pressurize));
         case (r_ps)
            S_ARRIVE: w_display = SEG_A;
            S_EVAC:   w_display = SEG_E;
            S_PRESS:  w_display = SEG_P;
            S_FAULT:  w_display = SEG_F;
            default:  w_display = SEG_BLANK;
         endcase
      end
   end

   assign bus.rstCounter = w_rst_counter;
   assign bus.display    = w_display;
   assign bus.busy       = w_busy;
   assign bus.fault      = w_fault;

endmodule
